// File: rtl/shreg_ser_if.sv
// Load/serial bus of shreg_ser. The bench drives the word, controls and
// serial fill through the master modport; the shift register is the slave.
interface shreg_ser_if #(
    parameter int W = 8
);
    localparam int CW = $clog2(W + 2);

    logic          ld_valid;
    logic          ld_ready;
    logic [W-1:0]  data_in;
    logic          msb_first;
    logic          ser_in;
    logic          sh_en;
    logic          abort;
    logic          ser_out;
    logic          ser_valid;
    logic [W-1:0]  data_out;
    logic [CW-1:0] cnt;
    logic          done;

    modport master (
        output ld_valid, data_in, msb_first, ser_in, sh_en, abort,
        input  ld_ready, ser_out, ser_valid, data_out, cnt, done
    );

    modport slave (
        input  ld_valid, data_in, msb_first, ser_in, sh_en, abort,
        output ld_ready, ser_out, ser_valid, data_out, cnt, done
    );
endinterface

// File: rtl/shreg_ser.sv
// Parallel-to-serial shift register with load handshake, bit-order select,
// pause and abort. Define SHREG_SER_PARITY_EN to append an even-parity bit.
module shreg_ser #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst_b,
    shreg_ser_if.slave bus
);
    localparam int CW = $clog2(W + 2);
`ifdef SHREG_SER_PARITY_EN
    localparam logic [CW-1:0] N = CW'(W + 1);
`else
    localparam logic [CW-1:0] N = CW'(W);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  data_q, data_nx;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic          dir_q, dir_nx;
    logic          done_q, done_nx;
    logic          par_slot;
    logic          data_bit;

`ifdef SHREG_SER_PARITY_EN
    logic par_q, par_nx;
    // With parity, the last counted slot carries the parity bit, not data.
    assign par_slot = (cnt_q == CW'(1));
`else
    assign par_slot = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef SHREG_SER_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            data_q <= data_nx;
            cnt_q  <= cnt_nx;
            dir_q  <= dir_nx;
            done_q <= done_nx;
`ifdef SHREG_SER_PARITY_EN
            par_q  <= par_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        data_nx  = data_q;
        cnt_nx   = cnt_q;
        dir_nx   = dir_q;
        done_nx  = 1'b0;
`ifdef SHREG_SER_PARITY_EN
        par_nx   = par_q;
`endif
        unique case (state)
            IDLE: begin
                // abort outranks a load even while idle
                if (!bus.abort && bus.ld_valid) begin
                    data_nx  = bus.data_in;
                    dir_nx   = bus.msb_first;
                    cnt_nx   = N;
                    state_nx = SHIFT;
`ifdef SHREG_SER_PARITY_EN
                    par_nx   = ^bus.data_in;
`endif
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (bus.sh_en) begin
                    if (!par_slot) begin
                        data_nx = dir_q ? {data_q[W-2:0], bus.ser_in}
                                        : {bus.ser_in, data_q[W-1:1]};
                    end
                    cnt_nx = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
        endcase
    end

    assign data_bit = dir_q ? data_q[W-1] : data_q[0];

`ifdef SHREG_SER_PARITY_EN
    assign bus.ser_out = par_slot ? par_q : data_bit;
`else
    assign bus.ser_out = data_bit;
`endif

    assign bus.ld_ready  = (state == IDLE);
    assign bus.ser_valid = (state == SHIFT);
    assign bus.data_out  = data_q;
    assign bus.cnt       = cnt_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_shreg_ser.sv
// Directed bench for shreg_ser (W=8): vector table for an LSB-first transfer
// plus hand-written sequences for pause, abort, back-to-back, reset and parity.
module tb_shreg_ser;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    shreg_ser_if #(.W(W)) bus ();

    shreg_ser #(.W(W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld_valid;
        logic [7:0] din;
        logic       sh_en;
        logic       so;
        logic       sv;
        logic       lr;
        logic       dn;
        logic [3:0] c;
        logic [7:0] d;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] snap();
        return {16'd0, bus.ser_out, bus.ser_valid, bus.ld_ready, bus.done, bus.cnt, bus.data_out};
    endfunction

    function automatic logic [31:0] mk(input logic so, input logic sv, input logic lr,
                                       input logic dn, input logic [3:0] c, input logic [7:0] d);
        return {16'd0, so, sv, lr, dn, c, d};
    endfunction

    function automatic vec_t mkv(input logic lv, input logic [7:0] din, input logic se,
                                 input logic so, input logic sv, input logic lr,
                                 input logic dn, input logic [3:0] c, input logic [7:0] d);
        vec_t v;
        v.ld_valid = lv; v.din = din; v.sh_en = se;
        v.so = so; v.sv = sv; v.lr = lr; v.dn = dn; v.c = c; v.d = d;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[10];
        logic       exp_msb[10];
        logic [7:0] w;

        bus.ld_valid  = 1'b0;
        bus.data_in   = 8'h00;
        bus.msb_first = 1'b0;
        bus.ser_in    = 1'b0;
        bus.sh_en     = 1'b0;
        bus.abort     = 1'b0;

        // reset asserts asynchronously, before any clock edge
        #2 rst_b = 1'b0;
        #1 check("reset_state", snap(), mk(0, 0, 1, 0, 4'd0, 8'h00));
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        check("idle_no_load", snap(), mk(0, 0, 1, 0, 4'd0, 8'h00));

`ifndef SHREG_SER_PARITY_EN
        // LSB-first 0xB4 with ser_in=1: one row per cycle after the edge
        tbl[0] = mkv(1, 8'hB4, 0,  0, 1, 0, 0, 4'd8, 8'hB4);
        tbl[1] = mkv(0, 8'h00, 1,  0, 1, 0, 0, 4'd7, 8'hDA);
        tbl[2] = mkv(0, 8'h00, 1,  1, 1, 0, 0, 4'd6, 8'hED);
        tbl[3] = mkv(0, 8'h00, 1,  0, 1, 0, 0, 4'd5, 8'hF6);
        tbl[4] = mkv(0, 8'h00, 1,  1, 1, 0, 0, 4'd4, 8'hFB);
        tbl[5] = mkv(0, 8'h00, 1,  1, 1, 0, 0, 4'd3, 8'hFD);
        tbl[6] = mkv(0, 8'h00, 1,  0, 1, 0, 0, 4'd2, 8'hFE);
        tbl[7] = mkv(0, 8'h00, 1,  1, 1, 0, 0, 4'd1, 8'hFF);
        tbl[8] = mkv(0, 8'h00, 1,  1, 0, 1, 1, 4'd0, 8'hFF);
        tbl[9] = mkv(0, 8'h00, 1,  1, 0, 1, 0, 4'd0, 8'hFF);
        bus.msb_first = 1'b0;
        bus.ser_in    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.ld_valid = tbl[i].ld_valid;
            bus.data_in  = tbl[i].din;
            bus.sh_en    = tbl[i].sh_en;
            tick();
            check($sformatf("lsb_vec%0d", i), snap(),
                  mk(tbl[i].so, tbl[i].sv, tbl[i].lr, tbl[i].dn, tbl[i].c, tbl[i].d));
        end

        // MSB-first 0xB4, ser_in=0, sh_en low in cycles 3 and 4
        exp_msb = '{1, 0, 1, 1, 1, 1, 0, 1, 0, 0};
        bus.msb_first = 1'b1;
        bus.ser_in    = 1'b0;
        bus.data_in   = 8'hB4;
        bus.ld_valid  = 1'b1;
        bus.sh_en     = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("msb_cycle%0d", i), {29'd0, bus.ser_out, bus.ser_valid, bus.done},
                  {29'd0, exp_msb[i-1], 1'b1, 1'b0});
            if (i == 4) check("msb_pause_cnt", 32'(bus.cnt), 32'd6);
            bus.sh_en = !(i == 3 || i == 4);
            tick();
        end
        check("msb_done_late", snap(), mk(0, 0, 1, 1, 4'd0, 8'h00));

        // abort after 3 shifts, then abort in IDLE blocks a load
        bus.msb_first = 1'b0;
        bus.data_in   = 8'hB4;
        bus.ld_valid  = 1'b1;
        bus.sh_en     = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        tick(); tick(); tick();
        check("abort_pre", snap(), mk(0, 1, 0, 0, 4'd5, 8'h16));
        bus.abort = 1'b1;
        tick();
        check("abort_done", snap(), mk(0, 0, 1, 0, 4'd0, 8'h16));
        bus.ld_valid = 1'b1;
        bus.data_in  = 8'h5A;
        tick();
        check("abort_idle_blocks_load", snap(), mk(0, 0, 1, 0, 4'd0, 8'h16));
        bus.abort    = 1'b0;
        bus.ld_valid = 1'b0;
        tick();

        // ld_valid held through a transfer, then back-to-back load of 0x5A
        w = 8'hB4;
        bus.ld_valid  = 1'b1;
        bus.data_in   = 8'hB4;
        bus.msb_first = 1'b0;
        bus.ser_in    = 1'b0;
        bus.sh_en     = 1'b1;
        tick();
        bus.data_in   = 8'h5A;
        bus.msb_first = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("b2b_a_cycle%0d", i), {24'd0, bus.ser_out, bus.ser_valid, bus.ld_ready, bus.cnt},
                  {24'd0, w[i-1], 1'b1, 1'b0, 4'(9 - i)});
            tick();
        end
        check("b2b_a_done", {29'd0, bus.done, bus.ld_ready, bus.data_out == 8'h00},
              {29'd0, 1'b1, 1'b1, 1'b1});
        tick();
        bus.ld_valid = 1'b0;
        w = 8'h5A;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("b2b_b_bit%0d", j), {28'd0, bus.ser_out, bus.ser_valid, bus.done, bus.ld_ready},
                  {28'd0, w[7-j], 1'b1, 1'b0, 1'b0});
            if (j == 0) check("b2b_b_cnt", 32'(bus.cnt), 32'd8);
            tick();
        end
        check("b2b_b_done", snap(), mk(0, 0, 1, 1, 4'd0, 8'h00));
`else
        // parity build: 0xB5 LSB-first, ser_in=0, parity bit 1 after 8 data bits
        w = 8'hB5;
        bus.msb_first = 1'b0;
        bus.ser_in    = 1'b0;
        bus.data_in   = 8'hB5;
        bus.ld_valid  = 1'b1;
        bus.sh_en     = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        check("par_load_cnt", 32'(bus.cnt), 32'd9);
        for (int i = 1; i <= 9; i++) begin
            check($sformatf("par_cycle%0d", i), {29'd0, bus.ser_out, bus.ser_valid, bus.done},
                  {29'd0, (i == 9) ? 1'b1 : w[i-1], 1'b1, 1'b0});
            if (i == 9) check("par_slot_data", 32'(bus.data_out), 32'h00);
            tick();
        end
        check("par_done", snap(), mk(0, 0, 1, 1, 4'd0, 8'h00));
        tick();
        check("par_done_once", snap(), mk(0, 0, 1, 0, 4'd0, 8'h00));
`endif

        // reset mid-transfer clears outputs without waiting for a clock edge
        bus.msb_first = 1'b0;
        bus.ser_in    = 1'b1;
        bus.data_in   = 8'hB4;
        bus.ld_valid  = 1'b1;
        bus.sh_en     = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        tick(); tick();
        check("rst_pre", 32'(bus.ser_valid), 32'd1);
        #2 rst_b = 1'b0;
        #1 check("rst_mid_transfer", snap(), mk(0, 0, 1, 0, 4'd0, 8'h00));
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        check("rst_no_done", snap(), mk(0, 0, 1, 0, 4'd0, 8'h00));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
